// File: rtl/vco_phase_decoder.sv
// VCO phase decoder: synchronizes the raw ring-oscillator phase bus, decodes
// the Johnson-coded phase into an index, accumulates per-sample phase
// advances over 2^OSR_LOG2 samples and presents each total through a
// valid/ready handshake with a sticky overrun flag.
module vco_phase_decoder #(
  parameter int PHASE_WIDTH = 11,
  parameter int OSR_LOG2    = 9,
  parameter int OUT_WIDTH   = 16
) (
`ifdef USE_POWER_PINS
  inout  wire                    vccd2,
  inout  wire                    vssd2,
`endif
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [PHASE_WIDTH-1:0] p,
  output logic                   vco_enb,
  output logic [OUT_WIDTH-1:0]   out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   overrun,
  output logic                   code_err
);

  // Number of legal phase states and derived widths.
  localparam int NSTATES = 2 * PHASE_WIDTH;
  localparam int IDX_W   = $clog2(NSTATES);
  // Worst case per word is (2N-1) * 2^OSR_LOG2, which fits in IDX_W + OSR_LOG2 bits.
  localparam int ACC_W   = IDX_W + OSR_LOG2;

  localparam logic [PHASE_WIDTH-1:0] PH_ONE  = PHASE_WIDTH'(1'b1);
  localparam logic [PHASE_WIDTH-1:0] PH_ZERO = {PHASE_WIDTH{1'b0}};
  localparam logic [IDX_W-1:0]       N_IDX   = IDX_W'(PHASE_WIDTH);
  localparam logic [IDX_W-1:0]       S_IDX   = IDX_W'(NSTATES);
  localparam logic [IDX_W-1:0]       IDX_0   = {IDX_W{1'b0}};
  localparam logic [ACC_W-1:0]       ACC_0   = {ACC_W{1'b0}};
  localparam logic [OSR_LOG2-1:0]    CNT_0   = {OSR_LOG2{1'b0}};
  localparam logic [OSR_LOG2-1:0]    CNT_1   = OSR_LOG2'(1'b1);
  localparam logic [OSR_LOG2-1:0]    CNT_MAX = {OSR_LOG2{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    WARMUP = 2'b01,
    RUN    = 2'b10
  } state_t;

  // Population count of a phase word.
  function automatic logic [IDX_W-1:0] count_ones(input logic [PHASE_WIDTH-1:0] v);
    logic [IDX_W-1:0] n;
    n = IDX_0;
    for (int i = 0; i < PHASE_WIDTH; i++) begin
      n = n + IDX_W'(v[i]);
    end
    return n;
  endfunction

  // True when v is a run of ones anchored at bit 0 (includes all-zero and all-one).
  function automatic logic is_thermo(input logic [PHASE_WIDTH-1:0] v);
    logic [PHASE_WIDTH-1:0] inc;
    inc = v + PH_ONE;
    return ((v & inc) == PH_ZERO);
  endfunction

  state_t                 state_r;
  state_t                 state_s;
  logic [1:0]             warm_cnt_r;
  logic [PHASE_WIDTH-1:0] p_meta_r;
  logic [PHASE_WIDTH-1:0] p_sync_r;
  logic [IDX_W-1:0]       idx_prev_r;
  logic [ACC_W-1:0]       acc_r;
  logic [OSR_LOG2-1:0]    cnt_r;
  logic                   vco_enb_r;
  logic [OUT_WIDTH-1:0]   out_data_r;
  logic                   out_valid_r;
  logic                   overrun_r;
  logic                   code_err_r;

  logic                   legal_s;
  logic [IDX_W-1:0]       code_idx_s;
  logic [IDX_W-1:0]       idx_s;
  logic [IDX_W-1:0]       delta_s;
  logic [ACC_W-1:0]       acc_sum_s;
  logic                   warm_done_s;
  logic                   load_prev_s;
  logic                   run_s;
  logic                   use_s;
  logic                   wrap_s;
  logic                   accept_s;

  // Two-flop synchronizer for the asynchronous phase bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_meta_r <= PH_ZERO;
      p_sync_r <= PH_ZERO;
    end else begin
      p_meta_r <= p;
      p_sync_r <= p_meta_r;
    end
  end

  // Johnson decode: low-anchored ones give k = popcount, otherwise low-anchored
  // zeros give k = N + zero count; anything else is an illegal code.
  always_comb begin
    legal_s    = 1'b0;
    code_idx_s = IDX_0;
    if (is_thermo(p_sync_r)) begin
      legal_s    = 1'b1;
      code_idx_s = count_ones(p_sync_r);
    end else if (is_thermo(~p_sync_r)) begin
      legal_s    = 1'b1;
      code_idx_s = N_IDX + count_ones(~p_sync_r);
    end else begin
      legal_s    = 1'b0;
      code_idx_s = IDX_0;
    end
  end

  // Effective index (held on illegal code) and modular phase advance.
  always_comb begin
    idx_s   = legal_s ? code_idx_s : idx_prev_r;
    delta_s = IDX_0;
    if (idx_s >= idx_prev_r) begin
      delta_s = idx_s - idx_prev_r;
    end else begin
      delta_s = idx_s + S_IDX - idx_prev_r;
    end
    acc_sum_s = acc_r + ACC_W'(delta_s);
  end

  // Next-state logic and the per-cycle qualifiers derived from the state.
  always_comb begin
    state_s     = state_r;
    warm_done_s = (warm_cnt_r == 2'd2);
    case (state_r)
      IDLE: begin
        if (en) begin
          state_s = WARMUP;
        end else begin
          state_s = IDLE;
        end
      end
      WARMUP: begin
        if (!en) begin
          state_s = IDLE;
        end else if (warm_done_s) begin
          state_s = RUN;
        end else begin
          state_s = WARMUP;
        end
      end
      RUN: begin
        if (!en) begin
          state_s = IDLE;
        end else begin
          state_s = RUN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    load_prev_s = (state_r == WARMUP) && en && warm_done_s;
    run_s       = (state_r == RUN) && en;
    use_s       = load_prev_s || run_s;
    wrap_s      = run_s && (cnt_r == CNT_MAX);
    accept_s    = out_valid_r && out_ready;
  end

  // State register, warm-up counter and VCO enable registered from next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      warm_cnt_r <= 2'd0;
      vco_enb_r  <= 1'b1;
    end else begin
      state_r   <= state_s;
      vco_enb_r <= (state_s == IDLE);
      if ((state_r == WARMUP) && (state_s == WARMUP)) begin
        warm_cnt_r <= warm_cnt_r + 2'd1;
      end else begin
        warm_cnt_r <= 2'd0;
      end
    end
  end

  // Previous-index tracking, accumulation, sample counting and code error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_prev_r <= IDX_0;
      acc_r      <= ACC_0;
      cnt_r      <= CNT_0;
      code_err_r <= 1'b0;
    end else begin
      code_err_r <= use_s && !legal_s;
      if (use_s) begin
        idx_prev_r <= idx_s;
      end
      if (run_s) begin
        cnt_r <= cnt_r + CNT_1;
        if (wrap_s) begin
          acc_r <= ACC_0;
        end else begin
          acc_r <= acc_sum_s;
        end
      end else begin
        // Outside RUN any partial word is discarded.
        acc_r <= ACC_0;
        cnt_r <= CNT_0;
      end
    end
  end

  // Output word register with valid/ready handshake and sticky overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_r  <= {OUT_WIDTH{1'b0}};
      out_valid_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      if (wrap_s) begin
        out_data_r  <= OUT_WIDTH'(acc_sum_s);
        out_valid_r <= 1'b1;
        if (out_valid_r && !out_ready) begin
          overrun_r <= 1'b1;
        end
      end else if (accept_s) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign vco_enb   = vco_enb_r;
  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign overrun   = overrun_r;
  assign code_err  = code_err_r;

endmodule

// File: tb/tb_vco_phase_decoder.sv
// Self-checking bench for vco_phase_decoder (OSR_LOG2 = 2, four samples per
// word). Directed scenarios followed by a randomized run, all compared each
// cycle against a behavioural model built from the phase-code rules.
module tb_vco_phase_decoder;
  localparam int N   = 11;
  localparam int OSR = 2;
  localparam int OW  = 16;
  localparam int S   = 2 * N;
  localparam int WS  = 1 << OSR;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          out_ready;
  logic [N-1:0]  p;
  logic          vco_enb;
  logic [OW-1:0] out_data;
  logic          out_valid;
  logic          overrun;
  logic          code_err;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state.
  bit           m_active;
  int           m_age;
  int           m_last;
  int           m_trail[$];
  int           m_word;
  bit           m_valid;
  bit           m_over;
  bit           m_err;
  bit           m_vco;
  logic [N-1:0] m_hist[$];

  vco_phase_decoder #(.PHASE_WIDTH(N), .OSR_LOG2(OSR), .OUT_WIDTH(OW)) dut (
    .clk(clk), .rst(rst), .en(en), .p(p), .vco_enb(vco_enb),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .overrun(overrun), .code_err(code_err)
  );

  always #10 clk = ~clk;

  // Johnson code for index k.
  function automatic logic [N-1:0] code_of(input int k);
    logic [N-1:0] ones;
    ones = '1;
    if (k <= N) return ~(ones << k);
    else return ones << (k - N);
  endfunction

  // Index of a phase word, or -1 if it is not one of the 2N legal codes.
  function automatic int decode(input logic [N-1:0] v);
    for (int k = 0; k < S; k++) begin
      if (code_of(k) === v) return k;
    end
    return -1;
  endfunction

  // Advance the model across one clock edge using the current inputs.
  function automatic void model_edge();
    int  sidx;
    int  idx;
    int  nw;
    int  last;
    bit  wload;
    bit  runs;
    bit  loaded;
    bit  accepted;
    nw = 0;
    loaded = 1'b0;
    if (rst) begin
      m_active = 1'b0; m_age = 0; m_last = 0; m_trail.delete();
      m_word = 0; m_valid = 1'b0; m_over = 1'b0; m_err = 1'b0; m_vco = 1'b1;
      m_hist.delete(); m_hist.push_back('0); m_hist.push_back('0);
      return;
    end
    sidx     = decode(m_hist[0]);
    wload    = m_active && en && (m_age == 2);
    runs     = m_active && en && (m_age >= 3);
    idx      = (sidx < 0) ? m_last : sidx;
    m_err    = (wload || runs) && (sidx < 0);
    accepted = m_valid && out_ready;
    if (wload) begin
      m_trail.delete();
      m_trail.push_back(idx);
    end
    if (runs) begin
      m_trail.push_back(idx);
      if (m_trail.size() == WS + 1) begin
        for (int i = 1; i < m_trail.size(); i++) nw += (m_trail[i] - m_trail[i-1] + S) % S;
        loaded = 1'b1;
        last = m_trail[$];
        m_trail.delete();
        m_trail.push_back(last);
      end
    end
    if (wload || runs) m_last = idx;
    if (loaded) begin
      if (m_valid && !out_ready) m_over = 1'b1;
      m_word  = nw;
      m_valid = 1'b1;
    end else if (accepted) begin
      m_valid = 1'b0;
    end
    if (!en) begin
      m_active = 1'b0; m_age = 0; m_trail.delete();
    end else if (!m_active) begin
      m_active = 1'b1; m_age = 0;
    end else if (m_age < 3) begin
      m_age++;
    end
    m_vco = !m_active;
    void'(m_hist.pop_front());
    m_hist.push_back(p);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("vco_enb", 32'(vco_enb), 32'(m_vco));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_data", 32'(out_data), 32'(m_word));
    chk("overrun", 32'(overrun), 32'(m_over));
    chk("code_err", 32'(code_err), 32'(m_err));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    int k;
    int words;
    int errs;
    int wsum;
    rst = 1'b1; en = 1'b0; out_ready = 1'b0; p = '0;
    step(); step();
    chk("rst_vco_enb", 32'(vco_enb), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_code_err", 32'(code_err), 32'd0);

    // Constant legal phase: every word is zero.
    rst = 1'b0; out_ready = 1'b1;
    p = code_of(int'($urandom_range(S - 1)));
    step(); step();
    en = 1'b1;
    step();
    chk("const_vco_after_en", 32'(vco_enb), 32'd0);
    words = 0;
    repeat (3 + 3 * WS) begin
      step();
      if (out_valid) begin
        words++;
        chk("const_word_zero", 32'(out_data), 32'd0);
      end
    end
    chk("const_word_count", 32'(words), 32'd3);
    en = 1'b0;
    step();
    chk("en_low_vco", 32'(vco_enb), 32'd1);
    step();

    // +1 per clock through the 21 -> 0 wrap: every word is 4.
    en = 1'b1; k = 18; words = 0;
    repeat (3 + 4 * WS) begin
      p = code_of(k);
      step();
      if (out_valid) begin
        words++;
        chk("ramp1_word", 32'(out_data), 32'd4);
      end
      k = (k + 1) % S;
    end
    chk("ramp1_word_count", 32'(words), 32'd3);
    en = 1'b0;
    step(); step();

    // +3 per clock, consumer stalled for two word periods.
    out_ready = 1'b0; en = 1'b1; k = int'($urandom_range(S - 1));
    repeat (3 + 2 * WS + 2) begin
      p = code_of(k);
      step();
      k = (k + 3) % S;
    end
    chk("ramp3_data", 32'(out_data), 32'd12);
    chk("ramp3_valid", 32'(out_valid), 32'd1);
    chk("ramp3_overrun", 32'(overrun), 32'd1);

    // Reset mid-RUN with a pending word, then restart with a +1 ramp.
    rst = 1'b1; p = code_of(k); k = (k + 1) % S;
    step();
    chk("midrst_vco_enb", 32'(vco_enb), 32'd1);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_data", 32'(out_data), 32'd0);
    chk("midrst_overrun", 32'(overrun), 32'd0);
    chk("midrst_code_err", 32'(code_err), 32'd0);
    rst = 1'b0;
    repeat (7) begin
      p = code_of(k); k = (k + 1) % S;
      step();
    end
    chk("restart_no_early_word", 32'(out_valid), 32'd0);
    p = code_of(k); k = (k + 1) % S;
    step();
    chk("restart_first_valid", 32'(out_valid), 32'd1);
    chk("restart_first_data", 32'(out_data), 32'd4);

    // Drop en mid-word while the word is still pending.
    repeat (2) begin
      p = code_of(k); k = (k + 1) % S;
      step();
    end
    en = 1'b0;
    step();
    chk("endrop_vco_off", 32'(vco_enb), 32'd1);
    chk("endrop_pending_valid", 32'(out_valid), 32'd1);
    chk("endrop_pending_data", 32'(out_data), 32'd4);
    out_ready = 1'b1;
    step();
    chk("endrop_accepted", 32'(out_valid), 32'd0);
    repeat (6) step();
    chk("endrop_no_partial", 32'(out_valid), 32'd0);

    // One illegal sample between index 5 and index 6.
    en = 1'b1; p = code_of(5);
    repeat (5) step();
    p = 11'b00000000101;
    step();
    p = code_of(6);
    errs = 0; wsum = 0;
    repeat (10) begin
      step();
      if (code_err) errs++;
      if (out_valid) wsum += int'(out_data);
    end
    chk("illegal_err_pulses", 32'(errs), 32'd1);
    chk("illegal_word_total", 32'(wsum), 32'd1);

    // Randomized traffic, including occasional reset and illegal codes.
    k = int'($urandom_range(S - 1));
    for (int c = 0; c < 600; c++) begin
      rst       = ($urandom_range(99) == 0);
      en        = ($urandom_range(15) != 0);
      out_ready = 1'($urandom_range(1));
      if ($urandom_range(9) == 0) begin
        p = N'($urandom);
      end else begin
        k = (k + int'($urandom_range(S - 1))) % S;
        p = code_of(k);
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
